// File: rtl/oled_frame_seq_if.sv
// Bundle of the frame sequencer's control, pixel-source and SPI panel signals.
// master = the sequencer itself, slave = the host/pixel source/panel side.
interface oled_frame_seq_if;
  logic        start;
  logic        busy;
  logic        done;
  logic        pix_ready;
  logic        pix_valid;
  logic [15:0] pix_data;
  logic [6:0]  pix_x;
  logic [5:0]  pix_y;
  logic        sclk;
  logic        mosi;
  logic        cs_n;
  logic        dc;

  modport master (
    input  start, pix_valid, pix_data,
    output busy, done, pix_ready, pix_x, pix_y, sclk, mosi, cs_n, dc
  );

  modport slave (
    output start, pix_valid, pix_data,
    input  busy, done, pix_ready, pix_x, pix_y, sclk, mosi, cs_n, dc
  );
endinterface

// File: rtl/oled_frame_seq.sv
// OLED frame sequencer: sends a column/row window command, then streams one
// RGB565 frame over SPI mode 3, pulling pixels through a valid/ready handshake.
module oled_frame_seq #(
  parameter int CLK_DIV = 4,
  parameter int H_PIX   = 96,
  parameter int V_PIX   = 64
) (
  input  logic             clk,
  input  logic             resetn,
  oled_frame_seq_if.master bus
);
  typedef enum logic [2:0] {IDLE, CMD, PIX_WAIT, PIX_HI, PIX_LO, CS_END, DONE} state_t;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [6:0] X_LAST   = 7'(H_PIX - 1);
  localparam logic [5:0] Y_LAST   = 6'(V_PIX - 1);

  state_t      state_reg, state_next;
  logic [7:0]  div_cnt_reg;
  logic        phase_hi_reg;
  logic [2:0]  bit_cnt_reg;
  logic [2:0]  byte_cnt_reg;
  logic [7:0]  tx_byte_reg;
  logic        mosi_reg;
  logic [7:0]  pix_lo_reg;
  logic [6:0]  pix_x_reg;
  logic [5:0]  pix_y_reg;

  logic sending, div_last, bit_end, byte_end, last_pix;

  function automatic logic [7:0] cmd_byte(input logic [2:0] idx);
    case (idx)
      3'd0:    cmd_byte = 8'h15;
      3'd2:    cmd_byte = 8'(H_PIX - 1);
      3'd3:    cmd_byte = 8'h75;
      3'd5:    cmd_byte = 8'(V_PIX - 1);
      default: cmd_byte = 8'h00;
    endcase
  endfunction

  assign sending  = (state_reg == CMD) || (state_reg == PIX_HI) || (state_reg == PIX_LO);
  assign div_last = (div_cnt_reg == DIV_LAST);
  assign bit_end  = sending && phase_hi_reg && div_last;
  assign byte_end = bit_end && (bit_cnt_reg == 3'd7);
  assign last_pix = (pix_x_reg == X_LAST) && (pix_y_reg == Y_LAST);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_reg <= IDLE;
    else         state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:     if (bus.start)     state_next = CMD;
      CMD:      if (byte_end && byte_cnt_reg == 3'd5) state_next = PIX_WAIT;
      PIX_WAIT: if (bus.pix_valid) state_next = PIX_HI;
      PIX_HI:   if (byte_end)      state_next = PIX_LO;
      PIX_LO:   if (byte_end)      state_next = last_pix ? CS_END : PIX_WAIT;
      CS_END:   if (div_last)      state_next = DONE;
      DONE:                        state_next = IDLE;
      default:                     state_next = IDLE;
    endcase
  end

  always_comb begin
    bus.busy      = 1'b0;
    bus.done      = 1'b0;
    bus.pix_ready = 1'b0;
    bus.cs_n      = 1'b1;
    bus.dc        = 1'b0;
    bus.sclk      = 1'b1;
    case (state_reg)
      CMD: begin
        bus.busy = 1'b1;
        bus.cs_n = 1'b0;
        bus.sclk = phase_hi_reg;
      end
      PIX_WAIT: begin
        bus.busy      = 1'b1;
        bus.cs_n      = 1'b0;
        bus.dc        = 1'b1;
        bus.pix_ready = 1'b1;
      end
      PIX_HI, PIX_LO: begin
        bus.busy = 1'b1;
        bus.cs_n = 1'b0;
        bus.dc   = 1'b1;
        bus.sclk = phase_hi_reg;
      end
      CS_END: begin
        bus.busy = 1'b1;
        bus.cs_n = 1'b0;
        bus.dc   = 1'b1;
      end
      DONE:    bus.done = 1'b1;
      default: ;
    endcase
  end

  assign bus.mosi  = mosi_reg;
  assign bus.pix_x = pix_x_reg;
  assign bus.pix_y = pix_y_reg;

  // Loading a byte presents its MSB immediately and keeps the remaining bits
  // in tx_byte_reg, so mosi only moves at the start of each sclk-low phase.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      div_cnt_reg  <= 8'd0;
      phase_hi_reg <= 1'b0;
      bit_cnt_reg  <= 3'd0;
      byte_cnt_reg <= 3'd0;
      tx_byte_reg  <= 8'd0;
      mosi_reg     <= 1'b0;
      pix_lo_reg   <= 8'd0;
      pix_x_reg    <= 7'd0;
      pix_y_reg    <= 6'd0;
    end else begin
      if (sending || state_reg == CS_END) div_cnt_reg <= div_last ? 8'd0 : div_cnt_reg + 8'd1;
      else                                div_cnt_reg <= 8'd0;

      if (!sending)      phase_hi_reg <= 1'b0;
      else if (div_last) phase_hi_reg <= ~phase_hi_reg;

      if (bit_end) bit_cnt_reg <= bit_cnt_reg + 3'd1;
      if (bit_end && bit_cnt_reg != 3'd7) begin
        mosi_reg    <= tx_byte_reg[7];
        tx_byte_reg <= {tx_byte_reg[6:0], 1'b0};
      end

      case (state_reg)
        IDLE: if (bus.start) begin
          byte_cnt_reg <= 3'd0;
          mosi_reg     <= cmd_byte(3'd0) >> 7;
          tx_byte_reg  <= cmd_byte(3'd0) << 1;
        end
        CMD: if (byte_end && byte_cnt_reg != 3'd5) begin
          byte_cnt_reg <= byte_cnt_reg + 3'd1;
          mosi_reg     <= cmd_byte(byte_cnt_reg + 3'd1) >> 7;
          tx_byte_reg  <= cmd_byte(byte_cnt_reg + 3'd1) << 1;
        end
        PIX_WAIT: if (bus.pix_valid) begin
          mosi_reg    <= bus.pix_data[15];
          tx_byte_reg <= {bus.pix_data[14:8], 1'b0};
          pix_lo_reg  <= bus.pix_data[7:0];
        end
        PIX_HI: if (byte_end) begin
          mosi_reg    <= pix_lo_reg[7];
          tx_byte_reg <= {pix_lo_reg[6:0], 1'b0};
        end
        PIX_LO: if (byte_end) begin
          if (last_pix) begin
            pix_x_reg <= 7'd0;
            pix_y_reg <= 6'd0;
          end else if (pix_x_reg == X_LAST) begin
            pix_x_reg <= 7'd0;
            pix_y_reg <= pix_y_reg + 6'd1;
          end else begin
            pix_x_reg <= pix_x_reg + 7'd1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_oled_frame_seq.sv
// Scoreboard bench for oled_frame_seq on a reduced 5x3 frame: stimulus pushes
// expected SPI bytes, a monitor decodes bytes on rising sclk and compares.
`timescale 1ns/1ps
module tb_oled_frame_seq;
  localparam int CLK_DIV = 4;
  localparam int H_PIX   = 5;
  localparam int V_PIX   = 3;
  localparam int N_PIX   = H_PIX * V_PIX;
  localparam int FRAME_BYTES = 6 + 2 * N_PIX;

  typedef struct packed {
    logic       contig;
    logic       dc;
    logic [7:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  oled_frame_seq_if bus();

  oled_frame_seq #(.CLK_DIV(CLK_DIV), .H_PIX(H_PIX), .V_PIX(V_PIX)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   bytes_seen = 0;
  int   done_count = 0;
  int   done_gap = 0;
  int   mosi_glitch = 0;
  int   last_rise_cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic void push_exp(input logic contig, input logic dc, input logic [7:0] data);
    exp_t e;
    e.contig = contig;
    e.dc     = dc;
    e.data   = data;
    exp_q.push_back(e);
  endfunction

  // Window command for a 5x3 panel: columns 0..4, rows 0..2.
  task automatic push_cmds();
    push_exp(1'b0, 1'b0, 8'h15);
    push_exp(1'b1, 1'b0, 8'h00);
    push_exp(1'b1, 1'b0, 8'h04);
    push_exp(1'b1, 1'b0, 8'h75);
    push_exp(1'b1, 1'b0, 8'h00);
    push_exp(1'b1, 1'b0, 8'h02);
  endtask

  task automatic start_frame();
    bytes_seen = 0;
    push_cmds();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check("start_accept", {bus.busy, bus.cs_n, bus.sclk, bus.dc}, 4'b1000);
  endtask

  task automatic serve_pixel(input int x, input int y, input logic [15:0] val,
                             input int delay, output bit ok);
    int t;
    int bad;
    t  = 0;
    ok = 1'b1;
    while (bus.pix_ready !== 1'b1 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (bus.pix_ready !== 1'b1) begin
      n_checks++;
      n_fail++;
      $display("FAIL pix_ready_timeout: pixel (%0d,%0d) not requested within %0d cycles", x, y, t);
      ok = 1'b0;
      return;
    end
    check("pix_xy", {bus.pix_x, bus.pix_y}, {7'(x), 6'(y)});
    bad = 0;
    for (int i = 0; i < delay; i++) begin
      @(negedge clk);
      if ({bus.sclk, bus.cs_n, bus.pix_ready, bus.dc} !== 4'b1011) bad++;
    end
    if (delay > 0) check("wait_hold_violations", bad, 0);
    push_exp(1'b0, 1'b1, val[15:8]);
    push_exp(1'b1, 1'b1, val[7:0]);
    bus.pix_data  = val;
    bus.pix_valid = 1'b1;
    @(negedge clk);
    check("ready_drop", bus.pix_ready, 1'b0);
    bus.pix_valid = 1'b0;
  endtask

  // Last sclk rise -> done: CLK_DIV cycles of the final high phase plus
  // CLK_DIV cycles of CS_END.
  task automatic wait_done();
    int t;
    t = 0;
    while (bus.done !== 1'b1 && t < 600) begin
      @(negedge clk);
      t++;
    end
    if (bus.done !== 1'b1) begin
      n_checks++;
      n_fail++;
      $display("FAIL done_timeout: done not seen within %0d cycles", t);
      return;
    end
    check("done_cs_n_busy", {bus.cs_n, bus.busy}, 2'b10);
    @(negedge clk);
    check("done_width", bus.done, 1'b0);
    check("done_gap", done_gap, 2 * CLK_DIV);
  endtask

  // Monitor: decodes SPI bytes on rising sclk and checks them against the queue.
  initial begin : monitor
    logic       sclk_q;
    logic       mosi_at_rise;
    logic [7:0] sh;
    int         bit_n;
    int         rise0;
    int         gap;
    exp_t       e;
    sclk_q = 1'b1;
    mosi_at_rise = 1'b0;
    sh = 8'd0;
    bit_n = 0;
    rise0 = 0;
    gap = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!resetn || bus.cs_n) begin
        bit_n = 0;
      end else begin
        if (bus.sclk && sclk_q && bus.mosi !== mosi_at_rise) mosi_glitch++;
        if (bus.sclk && !sclk_q) begin
          mosi_at_rise = bus.mosi;
          sh = {sh[6:0], bus.mosi};
          if (bit_n == 0) begin
            gap   = cyc - last_rise_cyc;
            rise0 = cyc;
          end
          last_rise_cyc = cyc;
          bit_n++;
          if (bit_n == 8) begin
            bit_n = 0;
            bytes_seen++;
            $display("spi byte %0d: dc=%0d data=%02h", bytes_seen, bus.dc, sh);
            if (exp_q.size() == 0) begin
              n_checks++;
              n_fail++;
              $display("FAIL unexpected_byte: got dc=%0d data=%02h, expected no byte", bus.dc, sh);
            end else begin
              e = exp_q.pop_front();
              check("spi_byte", {bus.dc, sh}, {e.dc, e.data});
              check("byte_span", cyc - rise0, 14 * CLK_DIV);
              if (e.contig) check("byte_gap", gap, 2 * CLK_DIV);
            end
          end
        end
      end
      if (resetn && bus.done) begin
        done_count++;
        done_gap = cyc - last_rise_cyc;
      end
      sclk_q = bus.sclk;
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    bit ok;
    logic [15:0] val;
    bus.start     = 1'b0;
    bus.pix_valid = 1'b0;
    bus.pix_data  = 16'h0000;
    resetn        = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", {bus.sclk, bus.mosi, bus.cs_n, bus.dc, bus.busy, bus.done, bus.pix_ready}, 7'b1010000);
    check("reset_xy", {bus.pix_x, bus.pix_y}, 13'd0);
    resetn = 1'b1;
    @(negedge clk);

    // Frame 1: 0x1234 first, a 100-cycle stall, stray start/valid during a send.
    start_frame();
    ok = 1'b1;
    for (int p = 0; p < N_PIX && ok; p++) begin
      val = (p == 0) ? 16'h1234 : 16'(((p / H_PIX) << 8) | (p % H_PIX));
      serve_pixel(p % H_PIX, p / H_PIX, val, (p == 2) ? 100 : 0, ok);
      if (ok && p == 5) begin
        bus.pix_valid = 1'b1;
        bus.pix_data  = 16'hDEAD;
        bus.start     = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (30) @(negedge clk);
        check("busy_after_stray_start", {bus.busy, bus.pix_ready}, 2'b10);
        bus.pix_valid = 1'b0;
      end
    end
    wait_done();
    check("frame1_bytes", bytes_seen, FRAME_BYTES);
    check("frame1_queue_drained", exp_q.size(), 0);
    check("frame1_done_pulses", done_count, 1);

    // Frame 2: asynchronous reset while pixel 10 (x=0, y=2) is shifting out.
    start_frame();
    ok = 1'b1;
    for (int p = 0; p <= 10 && ok; p++)
      serve_pixel(p % H_PIX, p / H_PIX, 16'(((p / H_PIX) << 8) | (p % H_PIX)), 0, ok);
    repeat (20) @(negedge clk);
    #3 resetn = 1'b0;
    #1;
    check("async_reset_outputs", {bus.sclk, bus.mosi, bus.cs_n, bus.dc, bus.busy, bus.done, bus.pix_ready}, 7'b1010000);
    check("async_reset_xy", {bus.pix_x, bus.pix_y}, 13'd0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);

    // Frame 3: a clean frame after the abort must replay from command byte 0.
    start_frame();
    ok = 1'b1;
    for (int p = 0; p < N_PIX && ok; p++)
      serve_pixel(p % H_PIX, p / H_PIX, 16'(((p / H_PIX) << 8) | (p % H_PIX)), 0, ok);
    wait_done();
    check("frame3_bytes", bytes_seen, FRAME_BYTES);
    check("frame3_queue_drained", exp_q.size(), 0);
    check("total_done_pulses", done_count, 2);
    check("mosi_stable_while_sclk_high", mosi_glitch, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
